ccff_chain_loader: RTL

- Sequences the configuration-chain load for a column of I/O and logic tiles: accepts bitstream words from the host port, serializes them MSB-first onto `ccff_head`, and gates shifting with a clock enable for the fabric's `prog_clk` gate.
- Counts shifted bits against the chain length, signals completion and supports abort.
- Sits between the bitstream source and the first tile's `ccff_head`; the last tile's `ccff_tail` returns to it.

---
 rtl/ccff_pkg.sv | 19 +
 rtl/ccff_word_serializer.sv | 49 ++++
 rtl/ccff_chain_loader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ccff_pkg.sv
// Shared types and defaults for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam int CHAIN_LEN_DEF = 64;
  localparam int WORD_W_DEF    = 8;

  // Counter must hold CHAIN_LEN+1 (marker shift) plus headroom.
  function automatic int cnt_w(input int chain_len);
    return $clog2(chain_len + 2);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Holds the not-yet-presented bits of the current host word; the word MSB
// bypasses this register on load, so it stores WORD_W-1 pending bits at most.
module ccff_word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              msb_o,
  output logic              empty_o
);

  localparam int RW = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [RW-1:0]     rem_q, rem_d;

  always_comb begin
    sr_d  = sr_q;
    rem_d = rem_q;
    if (clr_i) begin
      sr_d  = '0;
      rem_d = '0;
    end else if (load_i) begin
      sr_d  = word_i << 1;
      rem_d = RW'(WORD_W - 1);
    end else if (shift_i && (rem_q != '0)) begin
      sr_d  = sr_q << 1;
      rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      rem_q <= '0;
    end else begin
      sr_q  <= sr_d;
      rem_q <= rem_d;
    end
  end

  assign msb_o   = sr_q[WORD_W-1];
  assign empty_o = (rem_q == '0);

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serializes host words MSB-first onto ccff_head
// with a registered shift enable. Optional tail marker check: CCFF_TAIL_CHECK_EN.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int CNT_W     = cnt_w(CHAIN_LEN)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              shift_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);

`ifdef CCFF_TAIL_CHECK_EN
  localparam int TOTAL = CHAIN_LEN + 1;
`else
  localparam int TOTAL = CHAIN_LEN;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             shift_q, shift_d;
  logic             head_q, head_d;
  logic [CNT_W-1:0] issued;
  logic             marker_pend;
  logic             ser_clr, ser_load, ser_shift, ser_msb, ser_empty;

  // Shifts already scheduled: completed ones plus the one on the wire now.
  assign issued = bit_cnt_q + CNT_W'(shift_q);

`ifdef CCFF_TAIL_CHECK_EN
  assign marker_pend = (issued == '0);
`else
  assign marker_pend = 1'b0;
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  assign cfg_ready = (state_q == ST_LOAD) && ser_empty && !marker_pend &&
                     (issued != CNT_W'(TOTAL));

  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk_i   (prog_clk),
    .rst_ni  (pReset_n),
    .clr_i   (ser_clr),
    .load_i  (ser_load),
    .shift_i (ser_shift),
    .word_i  (cfg_data),
    .msb_o   (ser_msb),
    .empty_o (ser_empty)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = 1'b0;
    head_d    = 1'b0;
    ser_clr   = 1'b0;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    case (state_q)
      ST_LOAD: begin
        bit_cnt_d = issued;
        if (issued != CNT_W'(TOTAL)) begin
          if (marker_pend) begin
            shift_d = 1'b1;
            head_d  = 1'b1;
          end else if (!ser_empty) begin
            shift_d   = 1'b1;
            head_d    = ser_msb;
            ser_shift = 1'b1;
          end else if (cfg_valid && cfg_ready) begin
            shift_d  = 1'b1;
            head_d   = cfg_data[WORD_W-1];
            ser_load = 1'b1;
          end
        end else if (shift_q) begin
          // Final shift on the wire; leftover low bits of a partial word drop.
          ser_clr = 1'b1;
`ifdef CCFF_TAIL_CHECK_EN
          state_d = ccff_tail ? ST_DONE : ST_ERROR;
`else
          state_d = ST_DONE;
`endif
        end
      end
      default: begin
        if (start) begin
          state_d   = ST_LOAD;
          bit_cnt_d = '0;
          ser_clr   = 1'b1;
        end
      end
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      shift_d   = 1'b0;
      head_d    = 1'b0;
      ser_clr   = 1'b1;
      ser_load  = 1'b0;
      ser_shift = 1'b0;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= 1'b0;
      head_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      head_q    <= head_d;
    end
  end

  assign ccff_head = head_q;
  assign shift_en  = shift_q;
  assign busy      = (state_q == ST_LOAD);
  assign done      = (state_q == ST_DONE);
`ifdef CCFF_TAIL_CHECK_EN
  assign error     = (state_q == ST_ERROR);
`else
  assign error     = 1'b0;
`endif
  assign bit_count = bit_cnt_q;

endmodule
